// File: rtl/hpdl_line_editor_pkg.sv
// Shared constants, FSM state codes and character classes for the HPDL-1414 line editor.
package hpdl_pkg;

  localparam logic [7:0] CHAR_BKSP  = 8'h08;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] PRINT_LO   = 8'h20;
  localparam logic [7:0] PRINT_HI   = 8'h5F;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_CLEAR  = 2'd2;
  localparam logic [1:0] ST_SCROLL = 2'd3;

  typedef enum logic [2:0] {
    CLS_PRINT,
    CLS_BKSP,
    CLS_CR,
    CLS_FF,
    CLS_DROP
  } char_class_t;

endpackage

// File: rtl/hpdl_line_editor_classify.sv
// Combinational byte classifier: folds lower case onto upper case and sorts the byte
// into printable / backspace / carriage return / form feed / dropped.
module hpdl_char_classify
  import hpdl_pkg::*;
(
  input  logic [7:0]  i_byte,
  output char_class_t o_class,
  output logic [6:0]  o_code
);

  logic [7:0] w_fold;

  always_comb begin
    w_fold = i_byte;
    if (i_byte >= 8'h61 && i_byte <= 8'h7A) begin
      w_fold = i_byte - 8'h20;
    end
    o_code = w_fold[6:0];
    if (w_fold >= PRINT_LO && w_fold <= PRINT_HI) begin
      o_class = CLS_PRINT;
    end else if (i_byte == CHAR_BKSP) begin
      o_class = CLS_BKSP;
    end else if (i_byte == CHAR_CR) begin
      o_class = CLS_CR;
    end else if (i_byte == CHAR_FF) begin
      o_class = CLS_FF;
    end else begin
      o_class = CLS_DROP;
    end
  end

endmodule

// File: rtl/hpdl_line_editor.sv
// Turns received bytes into a synchronous write stream for the HPDL-1414 character memory.
// Define HPDL_SCROLL_EN to scroll the line left when a character arrives past the last place.
module hpdl_line_editor
  import hpdl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [6:0]    o_wr_data,
  output logic [AW:0]   o_cursor,
  output logic          o_busy
);

  localparam logic [AW:0] W_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] W_ONE   = (AW+1)'(1);

  logic [1:0]    r_state;
  logic [AW:0]   r_idx;
  logic [AW:0]   r_cursor;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [6:0]    r_wr_data;
  logic          r_rx_ready;
  logic          r_busy;
`ifdef HPDL_SCROLL_EN
  // Only the scroll rewrite reads the shadow, so it exists only in that build.
  logic [6:0]    r_shadow [DEPTH];
`endif

  char_class_t   w_class;
  logic [6:0]    w_code;
  logic          w_accept;
  logic [AW:0]   w_cur_dec;

  hpdl_char_classify u_classify (
    .i_byte  (i_rx_data),
    .o_class (w_class),
    .o_code  (w_code)
  );

  assign w_accept  = i_rx_valid && r_rx_ready;
  assign w_cur_dec = r_cursor - W_ONE;

  // Ready and busy are registered alongside the state so they always mirror it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_CLEAR;
      r_idx      <= '0;
      r_cursor   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= CHAR_SPACE[6:0];
      r_rx_ready <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_WRITE;
            r_rx_ready <= 1'b0;
            case (w_class)
              CLS_PRINT: begin
                if (r_cursor != W_DEPTH) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_cursor[AW-1:0];
                  r_wr_data <= w_code;
                  r_cursor  <= r_cursor + W_ONE;
`ifdef HPDL_SCROLL_EN
                  r_shadow[r_cursor[AW-1:0]] <= w_code;
                end else begin
                  // Address 0 goes out on the accept edge, taking what shifts into place 0.
                  for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    r_shadow[i] <= r_shadow[i+1];
                  end
                  r_shadow[DEPTH-1] <= w_code;
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= '0;
                  r_wr_data <= r_shadow[1];
                  r_idx     <= W_ONE;
                  r_state   <= ST_SCROLL;
                  r_busy    <= 1'b1;
`endif
                end
              end
              CLS_BKSP: begin
                if (r_cursor != '0) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= w_cur_dec[AW-1:0];
                  r_wr_data <= CHAR_SPACE[6:0];
                  r_cursor  <= w_cur_dec;
`ifdef HPDL_SCROLL_EN
                  r_shadow[w_cur_dec[AW-1:0]] <= CHAR_SPACE[6:0];
`endif
                end
              end
              CLS_CR: r_cursor <= '0;
              CLS_FF: begin
                r_state <= ST_CLEAR;
                r_idx   <= '0;
                r_busy  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          r_state    <= ST_IDLE;
          r_rx_ready <= 1'b1;
        end
        ST_CLEAR: begin
          if (r_idx != W_DEPTH) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_idx[AW-1:0];
            r_wr_data <= CHAR_SPACE[6:0];
            r_idx     <= r_idx + W_ONE;
`ifdef HPDL_SCROLL_EN
            r_shadow[r_idx[AW-1:0]] <= CHAR_SPACE[6:0];
`endif
          end else begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_cursor   <= '0;
          end
        end
`ifdef HPDL_SCROLL_EN
        ST_SCROLL: begin
          if (r_idx != W_DEPTH) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_idx[AW-1:0];
            r_wr_data <= r_shadow[r_idx[AW-1:0]];
            r_idx     <= r_idx + W_ONE;
          end else begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
`endif
        default: begin
          r_state    <= ST_IDLE;
          r_rx_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_cursor   = r_cursor;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_hpdl_line_editor.sv
// Directed bench for hpdl_line_editor with hand-computed write streams and cursor values.
module tb_hpdl_line_editor;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic       o_rx_ready;
  logic       o_wr_en;
  logic [3:0] o_wr_addr;
  logic [6:0] o_wr_data;
  logic [4:0] o_cursor;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  hpdl_line_editor #(.DEPTH(16), .AW(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_ready (o_rx_ready),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_cursor   (o_cursor),
    .o_busy     (o_busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ready at a negedge, presents the byte, returns at the next negedge.
  task automatic push(input logic [7:0] b);
    int n = 0;
    while (!o_rx_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("ready_wait", {31'd0, o_rx_ready}, 32'd1);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge CLK);
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic send(input logic [7:0] b, input logic exp_we, input logic [3:0] exp_addr,
                      input logic [6:0] exp_data, input logic [4:0] exp_cur);
    push(b);
    check("wr_en", {31'd0, o_wr_en}, {31'd0, exp_we});
    if (exp_we) begin
      check("wr_addr", {28'd0, o_wr_addr}, {28'd0, exp_addr});
      check("wr_data", {25'd0, o_wr_data}, {25'd0, exp_data});
    end
    check("cursor", {27'd0, o_cursor}, {27'd0, exp_cur});
    check("ready_low", {31'd0, o_rx_ready}, 32'd0);
    @(negedge CLK);
    check("ready_back", {31'd0, o_rx_ready}, 32'd1);
    check("wr_en_off", {31'd0, o_wr_en}, 32'd0);
  endtask

  task automatic expect_clear();
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      check("clr_we", {31'd0, o_wr_en}, 32'd1);
      check("clr_addr", {28'd0, o_wr_addr}, k);
      check("clr_data", {25'd0, o_wr_data}, 32'h20);
      check("clr_busy", {31'd0, o_busy}, 32'd1);
      check("clr_ready", {31'd0, o_rx_ready}, 32'd0);
    end
    @(negedge CLK);
    check("clr_done_ready", {31'd0, o_rx_ready}, 32'd1);
    check("clr_done_we", {31'd0, o_wr_en}, 32'd0);
    check("clr_done_busy", {31'd0, o_busy}, 32'd0);
    check("clr_done_cur", {27'd0, o_cursor}, 32'd0);
  endtask

  initial begin
    // Reset held for three edges
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_we", {31'd0, o_wr_en}, 32'd0);
    check("rst_ready", {31'd0, o_rx_ready}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd1);
    check("rst_cur", {27'd0, o_cursor}, 32'd0);
    check("rst_addr", {28'd0, o_wr_addr}, 32'd0);
    check("rst_data", {25'd0, o_wr_data}, 32'h20);
    RST = 1'b0;
    expect_clear();

    // "hi" folds to upper case
    send(8'h68, 1'b1, 4'd0, 7'h48, 5'd1);
    send(8'h69, 1'b1, 4'd1, 7'h49, 5'd2);

    // Backspace down to 0, then once more at 0
    send(8'h08, 1'b1, 4'd1, 7'h20, 5'd1);
    send(8'h08, 1'b1, 4'd0, 7'h20, 5'd0);
    send(8'h08, 1'b0, 4'd0, 7'h00, 5'd0);

    // Carriage return from cursor 5
    send(8'h61, 1'b1, 4'd0, 7'h41, 5'd1);
    send(8'h62, 1'b1, 4'd1, 7'h42, 5'd2);
    send(8'h63, 1'b1, 4'd2, 7'h43, 5'd3);
    send(8'h64, 1'b1, 4'd3, 7'h44, 5'd4);
    send(8'h65, 1'b1, 4'd4, 7'h45, 5'd5);
    send(8'h0D, 1'b0, 4'd0, 7'h00, 5'd0);

    // Dropped bytes and printable-range edges
    send(8'h07, 1'b0, 4'd0, 7'h00, 5'd0);
    send(8'h80, 1'b0, 4'd0, 7'h00, 5'd0);
    send(8'h60, 1'b0, 4'd0, 7'h00, 5'd0);
    send(8'h7B, 1'b0, 4'd0, 7'h00, 5'd0);
    send(8'h1F, 1'b0, 4'd0, 7'h00, 5'd0);
    send(8'h5F, 1'b1, 4'd0, 7'h5F, 5'd1);
    send(8'h20, 1'b1, 4'd1, 7'h20, 5'd2);
    send(8'h7A, 1'b1, 4'd2, 7'h5A, 5'd3);

    // Form feed
    push(8'h0C);
    check("ff_we", {31'd0, o_wr_en}, 32'd0);
    check("ff_busy", {31'd0, o_busy}, 32'd1);
    expect_clear();

    // Fill all 16 places with 'A'..'P'
    for (int k = 0; k < 16; k++) begin
      send(8'h41 + 8'(k), 1'b1, 4'(k), 7'h41 + 7'(k), 5'(k + 1));
    end

`ifdef HPDL_SCROLL_EN
    push(8'h51);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge CLK);
      check("scr_we", {31'd0, o_wr_en}, 32'd1);
      check("scr_addr", {28'd0, o_wr_addr}, k);
      check("scr_data", {25'd0, o_wr_data}, 32'h42 + k);
      check("scr_busy", {31'd0, o_busy}, 32'd1);
      check("scr_ready", {31'd0, o_rx_ready}, 32'd0);
      check("scr_cur", {27'd0, o_cursor}, 32'd16);
    end
    @(negedge CLK);
    check("scr_done_ready", {31'd0, o_rx_ready}, 32'd1);
    check("scr_done_busy", {31'd0, o_busy}, 32'd0);
`else
    send(8'h51, 1'b0, 4'd0, 7'h00, 5'd16);
    check("ovf_busy", {31'd0, o_busy}, 32'd0);
`endif

    // Reset on the fifth cycle of a form-feed clear
    push(8'h0C);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("pre_addr", {28'd0, o_wr_addr}, k);
    end
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_we", {31'd0, o_wr_en}, 32'd0);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd1);
    check("mid_rst_cur", {27'd0, o_cursor}, 32'd0);
    check("mid_rst_addr", {28'd0, o_wr_addr}, 32'd0);
    RST = 1'b0;
    expect_clear();

    send(8'h5A, 1'b1, 4'd0, 7'h5A, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hpdl_line_editor.md
Name: hpdl_line_editor

Overview:
- Sits between uart_receiver and the 16-place character memory that the HPDL-1414 scan logic reads.
- Takes each received byte and turns it into memory writes: display-range characters, backspace, carriage return and form-feed.
- Keeps a shadow copy of the display contents and a cursor.
- Replaces the edge-triggered address counting previously clocked off the receive strobe with a fully synchronous write stream.

Parameters:
- DEPTH, 16: number of display places. Must be a power of two, 4..16.
- AW, 4: memory address width; equals log2(DEPTH).

Ports:
- CLK  in  1  system clock (12 MHz).
- RST  in  1  synchronous reset, active-high.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  byte valid. Held until accepted.
- o_rx_ready  out  1  editor can accept a byte this cycle.
- o_wr_en  out  1  one-cycle write strobe to character memory.
- o_wr_addr  out  AW  write address.
- o_wr_data  out  7  HPDL character code.
- o_cursor  out  AW+1  cursor position, range 0..DEPTH; DEPTH means past the end.
- o_busy  out  1  multi-cycle sequence (clear or scroll) in progress.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. All outputs are registered.
- Handshake: a byte is accepted when i_rx_valid && o_rx_ready. o_rx_ready = 1 only in state IDLE.
- States: IDLE, WRITE, CLEAR, SCROLL.
- While RST=1: o_wr_en=0, o_rx_ready=0, o_busy=1, o_cursor=0, o_wr_addr=0, o_wr_data=0x20. State is forced to CLEAR with index 0.
- After RST falls: CLEAR runs DEPTH cycles, writing 0x20 to addresses 0..DEPTH-1 in order. The shadow is filled with 0x20. It then returns to IDLE and o_rx_ready=1 on the following cycle.
- RST asserted mid-sequence aborts the sequence and restarts CLEAR from address 0.
- Character fold: 0x61..0x7A have 0x20 subtracted. The printable range after folding is 0x20..0x5F.
- Printable byte, accepted in cycle N, with cursor < DEPTH:
  - Cycle N+1: o_wr_en=1, o_wr_addr=cursor, o_wr_data=char[6:0]; shadow updated; cursor increments (WRITE state).
  - Cycle N+2: back in IDLE, o_rx_ready=1.
- Printable byte with cursor == DEPTH: see Optional Feature.
- 0x08 (backspace), cursor > 0: cursor decrements, then 0x20 is written at the new cursor with the same timing as a printable write. At cursor 0: byte consumed, no write, cursor unchanged.
- 0x0D (carriage return): cursor = 0, no write, one-cycle pass through WRITE with o_wr_en=0.
- 0x0C (form feed): CLEAR sequence as above, then cursor = 0.
- All other bytes (0x00..0x1F except the above, 0x60, 0x7B..0xFF) are consumed and dropped. No write, cursor unchanged.
- o_busy = 1 in CLEAR and SCROLL, 0 otherwise.
- Writes never exceed one per cycle. o_wr_addr is always < DEPTH. Cursor arithmetic is AW+1 bits and never wraps.

Optional Feature:
- Macro: HPDL_SCROLL_EN.
- Defined: a printable byte at cursor == DEPTH shifts the shadow one place left (place i takes place i+1) and puts the new character at DEPTH-1. SCROLL then rewrites addresses 0..DEPTH-1 over DEPTH consecutive cycles starting N+1. Cursor stays at DEPTH. o_rx_ready=0 for the whole sequence.
- Not defined: a printable byte at cursor == DEPTH is consumed and dropped with no write. SCROLL state and the shift logic are absent.

Decomposition:
- Package hpdl_pkg holds:
  - Constants CHAR_BKSP=0x08, CHAR_CR=0x0D, CHAR_FF=0x0C, CHAR_SPACE=0x20.
  - PRINT_LO=0x20, PRINT_HI=0x5F.
  - State encoding for IDLE, WRITE, CLEAR, SCROLL.
  - A char-class encoding: PRINT, BKSP, CR, FF, DROP.
- One sub-module, hpdl_char_classify (combinational): 8-bit byte in, class plus folded 7-bit code out.

Test Plan:
- Reset release: RST high 3 cycles, then low → 16 writes of 0x20 to addresses 0..15 on consecutive cycles, o_rx_ready rises 1 cycle after the last write, o_cursor=0.
- Send "hi" (0x68, 0x69) → write (addr 0, 0x48) then (addr 1, 0x49), each 1 cycle after acceptance; o_cursor=2.
- Backspace path: at cursor 2 send 0x08 → write (addr 1, 0x20), o_cursor=1. At cursor 0 send 0x08 → no write, o_cursor=0.
- Special and dropped bytes: 0x0D at cursor 5 → o_cursor=0, no write. 0x0C → 16 space writes, o_cursor=0. Bytes 0x07 and 0x80 → no write, cursor unchanged.
- Overflow: fill 16 chars 'A'..'P' then send 'Q'.
  - Without HPDL_SCROLL_EN: no write, o_cursor=16.
  - With HPDL_SCROLL_EN: 16 writes giving "BCDEFGHIJKLMNOPQ", o_busy=1 throughout.
- Mid-sequence reset: assert RST on the 5th cycle of a CLEAR → after release, CLEAR restarts at address 0 and completes all 16 writes.
